// File: rtl/uart_pkg.sv
// Shared definitions for the counter UART transmitter: FSM encoding and
// frame constants.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam int   DATA_BITS       = 8;
  localparam int   BIT_IDX_W       = $clog2(DATA_BITS);

endpackage

// File: rtl/uart_byte_fifo.sv
// Small synchronous FIFO. Pointers wrap modulo DEPTH; the fill level is kept
// in its own counter so full and empty never alias.
module uart_byte_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  // A full FIFO refuses a push even when a pop happens on the same edge.
  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];
  assign level   = level_q;

  // Pointer advance and level bookkeeping for the coming edge.
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q;
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Control state: pointers and level, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/counter_uart_tx.sv
// UART 8N1 transmitter fed from a byte FIFO. Bytes go out LSB first; frames
// queued in the FIFO are sent back to back with no idle bit between them.
module counter_uart_tx
  import uart_pkg::*;
#(
  parameter  int CLKS_PER_BIT = 87,
  parameter  int FIFO_DEPTH   = 4,
  localparam int LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy,
  output logic [LVL_W-1:0]     fifo_level
);

  localparam int                BAUD_W      = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);

  uart_state_e            state_q, state_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   tx_q, tx_d;

  logic                   fifo_push, fifo_pop;
  logic                   fifo_full, fifo_empty;
  logic [DATA_BITS-1:0]   fifo_dout;
  logic                   baud_done, last_bit;

  uart_byte_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (in_data),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready  = ~fifo_full;
  assign fifo_push = in_valid & in_ready;
  assign baud_done = (baud_q == '0);
  assign last_bit  = (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1));
  assign tx        = tx_q;
  assign busy      = (state_q != ST_IDLE) | (fifo_level != '0);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state selection; each bit period ends when the baud counter hits 0.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (!fifo_empty)           state_d = ST_START;
      ST_START: if (baud_done)             state_d = ST_DATA;
      ST_DATA:  if (baud_done && last_bit) state_d = ST_STOP;
      ST_STOP:  if (baud_done)             state_d = fifo_empty ? ST_IDLE : ST_START;
      default:                             state_d = ST_IDLE;
    endcase
  end

  // Per-state outputs: FIFO pop, next line level, baud/bit counters, shifter.
  always_comb begin
    fifo_pop  = 1'b0;
    tx_d      = tx_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          tx_d     = 1'b0;
          baud_d   = BAUD_RELOAD;
        end
      end
      ST_START: begin
        if (baud_done) begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_idx_d = '0;
          baud_d    = BAUD_RELOAD;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_d = BAUD_RELOAD;
          if (last_bit) begin
            tx_d = UART_IDLE_LEVEL;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_done) begin
          baud_d = BAUD_RELOAD;
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            tx_d     = 1'b0;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      default: begin
        tx_d = UART_IDLE_LEVEL;
      end
    endcase
  end

  // Control registers: line level and counters, forced idle by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q      <= UART_IDLE_LEVEL;
      baud_q    <= '0;
      bit_idx_q <= '0;
    end else begin
      tx_q      <= tx_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  // Shift register holds payload only; it is always loaded before use.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

endmodule

// File: tb/tb_counter_uart_tx.sv
// Bench for counter_uart_tx: a frame-schedule reference model predicts the
// line level, FIFO level, busy and in_ready after every clock edge.
module tb_counter_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int FRAME = 10 * CPB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          tx;
  logic          busy;
  logic [LW-1:0] fifo_level;

  always #5 clk = ~clk;

  counter_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  // Each accepted byte with the edge on which its start bit begins.
  typedef struct {
    logic [7:0] b;
    int         st;
  } ent_t;

  ent_t mq[$];
  int   last_end = 0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Bytes accepted but whose start bit has not begun by edge t.
  function automatic int m_level(input int t);
    int n = 0;
    foreach (mq[i]) if (mq[i].st > t) n++;
    return n;
  endfunction

  function automatic bit m_active(input int t);
    foreach (mq[i]) if (t >= mq[i].st && t < mq[i].st + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_pop_at(input int t);
    foreach (mq[i]) if (mq[i].st == t) return 1'b1;
    return 1'b0;
  endfunction

  // Line level after edge t: start bit, 8 data bits LSB first, stop bit.
  function automatic int m_tx(input int t);
    int k;
    foreach (mq[i]) begin
      if (t >= mq[i].st && t < mq[i].st + FRAME) begin
        k = (t - mq[i].st) / CPB;
        if (k == 0) return 0;
        if (k == 9) return 1;
        return int'(mq[i].b[k-1]);
      end
    end
    return 1;
  endfunction

  // One clock: update model with the inputs seen at the edge, then check.
  task automatic step(output bit acc);
    ent_t e;
    acc = in_valid && rst_n && (m_level(cyc) != DEPTH);
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      mq.delete();
      last_end = 0;
      acc = 1'b0;
    end else begin
      while (mq.size() > 0 && mq[0].st + FRAME <= cyc) void'(mq.pop_front());
      if (acc) begin
        e.b  = in_data;
        e.st = (cyc + 1 > last_end) ? cyc + 1 : last_end;
        mq.push_back(e);
        last_end = e.st + FRAME;
      end
    end
    #1;
    chk("tx", tx, m_tx(cyc));
    chk("fifo_level", fifo_level, m_level(cyc));
    chk("busy", busy, (m_active(cyc) || m_level(cyc) != 0));
    chk("in_ready", in_ready, (m_level(cyc) != DEPTH));
  endtask

  task automatic run(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(a);
  endtask

  task automatic reset_now();
    rst_n = 1'b0;
    mq.delete();
    last_end = 0;
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_level", fifo_level, 0);
  endtask

  initial begin
    bit         acc;
    int         idx;
    int         target;
    int         guard;
    bit         saw_not_ready;
    logic [9:0] pat;

    // Reset state and quiet line afterwards.
    #1;
    reset_now();
    run(3);
    rst_n = 1'b1;
    run(100);

    // Single byte 0x14, checked against a hand-built bit pattern.
    pat = {1'b1, 8'h14, 1'b0};
    in_data  = 8'h14;
    in_valid = 1'b1;
    step(acc);
    in_valid = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      step(acc);
      chk("frame14_bit", tx, pat[i / CPB]);
    end
    step(acc);
    chk("busy_drop", busy, 0);
    run(10);

    // Three bytes on consecutive cycles: contiguous frames.
    for (int i = 0; i < 3; i++) begin
      in_data  = 8'h14 + 8'(i);
      in_valid = 1'b1;
      step(acc);
    end
    in_valid = 1'b0;
    run(3 * FRAME + 10);

    // Backpressure with a held valid, 16 incrementing bytes.
    idx = 0;
    saw_not_ready = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b1;
    for (int i = 0; i < 1000 && idx < 16; i++) begin
      step(acc);
      if (!in_ready) saw_not_ready = 1'b1;
      if (acc) begin
        idx++;
        in_data = 8'(idx);
        if (idx == 16) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    if (idx < 16) chk("bp_timeout", idx, 16);
    chk("bp_ready_fell", saw_not_ready, 1);
    run(5 * FRAME);

    // Reset asserted during data bit 3 of a frame with another byte queued.
    in_data  = 8'hA5;
    in_valid = 1'b1;
    step(acc);
    in_data  = 8'h3C;
    step(acc);
    in_valid = 1'b0;
    target = mq[0].st + 4 * CPB + 1;
    while (cyc < target) step(acc);
    chk("pre_rst_busy", busy, 1);
    reset_now();
    run(2);
    rst_n = 1'b1;
    run(100);

    // Push and pop on one edge at level 3, then a refused push at level 4.
    for (int i = 0; i < 4; i++) begin
      in_data  = 8'($urandom);
      in_valid = 1'b1;
      step(acc);
    end
    in_valid = 1'b0;
    guard = 0;
    while (!(m_pop_at(cyc + 1) && m_level(cyc) == 3) && guard < 200) begin
      step(acc);
      guard++;
    end
    chk("l3_before", fifo_level, 3);
    in_data  = 8'($urandom);
    in_valid = 1'b1;
    step(acc);
    chk("pushpop_l3", fifo_level, 3);
    in_data = 8'($urandom);
    step(acc);
    chk("fill_l4", fifo_level, 4);
    in_data = 8'($urandom);
    guard = 0;
    while (!m_pop_at(cyc + 1) && guard < 200) begin
      step(acc);
      guard++;
    end
    chk("full_ready_low", in_ready, 0);
    step(acc);
    chk("refused_level", fifo_level, 3);
    step(acc);
    chk("retry_level", fifo_level, 4);
    in_valid = 1'b0;
    run(6 * FRAME);

    // Randomised traffic at several offered loads.
    for (int ph = 0; ph < 4; ph++) begin
      int prob;
      prob = (ph == 0) ? 3 : (ph == 1) ? 20 : (ph == 2) ? 90 : 50;
      for (int i = 0; i < 600; i++) begin
        in_valid = ($urandom_range(0, 99) < prob);
        in_data  = 8'($urandom);
        step(acc);
      end
    end
    in_valid = 1'b0;
    run(6 * FRAME);
    chk("final_idle_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
